// File: rtl/bf_pixel_scheduler.sv
// bf_pixel_scheduler
// Sequences a beamforming frame pixel by pixel. For each pixel it streams
// CHANNELS sample-memory reads, waits for the datapath result (bounded by
// LAT_MAX cycles), and offers the result on a valid/ready output port.
//
// Ports
//   clk, rst            : clock (rising edge), synchronous active-high reset
//   i_start, i_abort    : frame start (honoured in IDLE only), frame abort
//   i_mode              : 0 = DAS, 1 = DMAS, latched when a start is accepted
//   o_mem_addr/o_mem_rd_en : sample-memory read port (1-cycle read latency)
//   o_ch_valid/o_ch_first/o_ch_last : datapath input qualifiers
//   o_dp_clear, o_dp_mode : accumulator clear pulse and latched mode
//   i_dp_result/i_dp_result_valid : datapath output (one beat per pixel)
//   o_pix_data/o_pix_idx/o_pix_valid/i_pix_ready : pixel output handshake
//   o_busy, o_done, o_err : frame active, completion pulse, sticky timeout
module bf_pixel_scheduler #(
  parameter int CHANNELS = 128,
  parameter int PIXELS   = 1,
  parameter int ADDR_W   = 16,
  parameter int LAT_MAX  = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic                i_abort,
  input  logic                i_mode,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic                o_mem_rd_en,
  output logic                o_ch_valid,
  output logic                o_ch_first,
  output logic                o_ch_last,
  output logic                o_dp_clear,
  output logic                o_dp_mode,
  input  logic signed [16:0]  i_dp_result,
  input  logic                i_dp_result_valid,
  output logic signed [16:0]  o_pix_data,
  output logic [15:0]         o_pix_idx,
  output logic                o_pix_valid,
  input  logic                i_pix_ready,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err
);

  localparam int KW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PW = (PIXELS > 1) ? $clog2(PIXELS) : 1;
  localparam int WW = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

  localparam logic [KW-1:0] K_LAST = KW'(CHANNELS - 1);
  localparam logic [PW-1:0] P_LAST = PW'(PIXELS - 1);
  localparam logic [WW-1:0] W_LAST = WW'(LAT_MAX - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    WAIT   = 2'd2,
    OUTPUT = 2'd3
  } state_t;

  state_t              r_state;
  logic [KW-1:0]       r_k;
  logic [PW-1:0]       r_p;
  logic [WW-1:0]       r_wait_cnt;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic                r_mem_rd_en;
  logic                r_ch_valid;
  logic                r_ch_first;
  logic                r_ch_last;
  logic                r_dp_clear;
  logic                r_dp_mode;
  logic signed [16:0]  r_pix_data;
  logic [15:0]         r_pix_idx;
  logic                r_pix_valid;
  logic                r_busy;
  logic                r_done;
  logic                r_err;

  // All outputs are registered; each state's outputs are set up on the edge
  // that enters it, so o_mem_rd_en is high exactly while the FSM is in STREAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_k         <= '0;
      r_p         <= '0;
      r_wait_cnt  <= '0;
      r_mem_addr  <= '0;
      r_mem_rd_en <= 1'b0;
      r_ch_valid  <= 1'b0;
      r_ch_first  <= 1'b0;
      r_ch_last   <= 1'b0;
      r_dp_clear  <= 1'b0;
      r_dp_mode   <= 1'b0;
      r_pix_data  <= '0;
      r_pix_idx   <= '0;
      r_pix_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_dp_clear <= 1'b0;
      // Read data arrives one cycle after the strobe, so the channel
      // qualifiers are the strobe and its channel index delayed by one.
      r_ch_valid <= r_mem_rd_en;
      r_ch_first <= r_mem_rd_en && (r_k == '0);
      r_ch_last  <= r_mem_rd_en && (r_k == K_LAST);

      if (i_abort && (r_state != IDLE)) begin
        // Abort beats every other event, including a pending handshake.
        r_state     <= IDLE;
        r_mem_rd_en <= 1'b0;
        r_ch_valid  <= 1'b0;
        r_ch_first  <= 1'b0;
        r_ch_last   <= 1'b0;
        r_pix_valid <= 1'b0;
        r_busy      <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (i_start) begin
              r_state     <= STREAM;
              r_dp_mode   <= i_mode;
              r_p         <= '0;
              r_k         <= '0;
              r_err       <= 1'b0;
              r_mem_addr  <= '0;
              r_mem_rd_en <= 1'b1;
              r_dp_clear  <= 1'b1;
              r_busy      <= 1'b1;
            end
          end

          STREAM: begin
            if (r_k == K_LAST) begin
              r_mem_rd_en <= 1'b0;
              r_wait_cnt  <= '0;
              r_state     <= WAIT;
            end else begin
              r_k        <= r_k + KW'(1);
              r_mem_addr <= r_mem_addr + ADDR_W'(1);
            end
          end

          WAIT: begin
            // A result arriving in the last allowed cycle still wins over
            // the timeout.
            if (i_dp_result_valid) begin
              r_pix_data  <= i_dp_result;
              r_pix_idx   <= 16'(r_p);
              r_pix_valid <= 1'b1;
              r_state     <= OUTPUT;
            end else if (r_wait_cnt == W_LAST) begin
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end else begin
              r_wait_cnt <= r_wait_cnt + WW'(1);
            end
          end

          OUTPUT: begin
            if (i_pix_ready) begin
              r_pix_valid <= 1'b0;
              if (r_p == P_LAST) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                // Addresses are contiguous across pixels: the next pixel's
                // first address directly follows the previous pixel's last.
                r_p         <= r_p + PW'(1);
                r_k         <= '0;
                r_mem_addr  <= r_mem_addr + ADDR_W'(1);
                r_mem_rd_en <= 1'b1;
                r_dp_clear  <= 1'b1;
                r_state     <= STREAM;
              end
            end
          end

          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign o_mem_addr  = r_mem_addr;
  assign o_mem_rd_en = r_mem_rd_en;
  assign o_ch_valid  = r_ch_valid;
  assign o_ch_first  = r_ch_first;
  assign o_ch_last   = r_ch_last;
  assign o_dp_clear  = r_dp_clear;
  assign o_dp_mode   = r_dp_mode;
  assign o_pix_data  = r_pix_data;
  assign o_pix_idx   = r_pix_idx;
  assign o_pix_valid = r_pix_valid;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_err       = r_err;

endmodule
